pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives write-enables and bubble/flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazard sources: load-use RAW, taken branch/jump in EX, and a multi-cycle mul/div unit in EX. Owns a small FSM and a mul/div latency counter.

Parameters:
MULDIV_LAT, 8, total EX-stage cycles of a mul/div op; the op's start cycle counts as cycle 1; legal range 2..255.
CNT_W, 8, width of the latency counter; must hold MULDIV_LAT.

Ports:
Clk_40  in  1  pipeline clock, rising edge.
Reset_40  in  1  asynchronous, active-low reset.
Rs_ID_40  in  5  rs field of the instruction in ID.
Rt_ID_40  in  5  rt field of the instruction in ID.
MemRead_EX_40  in  1  instruction in EX is a load.
Rt_EX_40  in  5  destination rt of the instruction in EX.
BranchTaken_EX_40  in  1  branch/jump resolved taken in EX this cycle.
MulDivStart_EX_40  in  1  valid mul/div op is in EX this cycle.
PCWrite_40  out  1  PC update enable.
IF_ID_Write_40  out  1  IF/ID load enable.
IF_ID_Flush_40  out  1  IF/ID loads NOP.
ID_EX_Bubble_40  out  1  ID/EX loads zeroed controls.
EX_MEM_Write_40  out  1  EX/MEM load enable.
EX_MEM_Bubble_40  out  1  EX/MEM loads zeroed controls.
MulDivBusy_40  out  1  high while the FSM is in MD_BUSY.

Behaviour:
- States: RUN, MD_BUSY. Md counter: CNT_W bits. All outputs are combinational from state and inputs.
- Reset low (async, any time, including mid-MD_BUSY): state = RUN, counter = 0. Outputs while in reset: PCWrite = 0, IF_ID_Write = 0, EX_MEM_Write = 0, IF_ID_Flush = 1, ID_EX_Bubble = 1, EX_MEM_Bubble = 1, MulDivBusy = 0.
- After reset release, RUN defaults: PCWrite = 1, IF_ID_Write = 1, EX_MEM_Write = 1, all flush/bubble outputs = 0.
- Load-use (RUN only):
  - Condition: MemRead_EX = 1, Rt_EX != 0, and Rt_EX equals Rs_ID or Rt_ID.
  - Response: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1 for that cycle. Exactly one bubble is inserted; the hazard clears naturally on the next cycle.
- Branch taken (RUN): IF_ID_Flush = 1, ID_EX_Bubble = 1, PCWrite = 1. It has priority over load-use because the stalled instruction is being squashed.
- Mul/div in RUN:
  - MulDivStart = 1 with BranchTaken = 0: next state MD_BUSY, counter <= MULDIV_LAT-2.
  - On the start cycle: PCWrite = 0, IF_ID_Write = 0, EX_MEM_Write = 1, EX_MEM_Bubble = 1, and no ID_EX_Bubble, so the op is held in EX.
- MD_BUSY:
  - Held outputs: PCWrite = 0, IF_ID_Write = 0, EX_MEM_Bubble = 1, MulDivBusy = 1. MEM/WB keeps draining.
  - Counter decrements each cycle. When the counter is 0: state <= RUN, and outputs are RUN defaults for that cycle, so the result enters EX/MEM on that edge.
  - Total freeze of PC and IF/ID = MULDIV_LAT-1 cycles (start cycle plus MULDIV_LAT-2 busy cycles).
- Inputs ignored in MD_BUSY: BranchTaken, MulDivStart, load-use. EX holds the mul/div, so none can be valid.
- Simultaneous BranchTaken and MulDivStart in RUN: the branch wins and no MD_BUSY entry occurs (decoder guarantees exclusivity; the controller stays safe regardless).
- The MEM/WB register is never stalled by this block.

Optional Feature:
HAZARD_PERF_CNT_EN. When defined:
- Adds output StallCycles_40 [31:0]. It increments on every post-reset cycle with PCWrite = 0, saturates at 0xFFFFFFFF, and resets to 0.
- Adds output FlushCount_40 [15:0]. It increments on every IF_ID_Flush = 1 post-reset cycle, wraps at 0xFFFF, and resets to 0.

When undefined, neither port nor counter exists and all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles, then released with all inputs 0 -> outputs at reset values during reset; RUN defaults on the first cycle after release; MulDivBusy = 0.
- Load-use: MemRead_EX = 1, Rt_EX = 5, Rs_ID = 5 -> one cycle with PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1. Repeat with Rt_EX = 0 -> no stall.
- Branch and load-use together (BranchTaken = 1, MemRead_EX = 1, Rt_EX = Rt_ID = 9) -> IF_ID_Flush = 1, ID_EX_Bubble = 1, PCWrite = 1.
- MULDIV_LAT = 8, one-cycle MulDivStart pulse -> PCWrite = 0 for exactly 7 consecutive cycles; MulDivBusy high for 6; EX_MEM_Bubble high for 7; RUN defaults on cycle 8.
- Reset low asynchronously mid-MD_BUSY (counter = 3) -> immediate reset outputs; after release, state RUN and the next MulDivStart yields the full 7-cycle freeze.
- HAZARD_PERF_CNT_EN defined: one load-use stall plus one mul/div (LAT = 8) plus two branches -> StallCycles = 8, FlushCount = 2.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and multi-cycle mul/div.
// Optional HAZARD_PERF_CNT_EN adds stall-cycle and flush counters.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 8,
    parameter int CNT_W      = 8
) (
    input  logic        Clk_40,
    input  logic        Reset_40,
    input  logic [4:0]  Rs_ID_40,
    input  logic [4:0]  Rt_ID_40,
    input  logic        MemRead_EX_40,
    input  logic [4:0]  Rt_EX_40,
    input  logic        BranchTaken_EX_40,
    input  logic        MulDivStart_EX_40,
    output logic        PCWrite_40,
    output logic        IF_ID_Write_40,
    output logic        IF_ID_Flush_40,
    output logic        ID_EX_Bubble_40,
    output logic        EX_MEM_Write_40,
    output logic        EX_MEM_Bubble_40,
    output logic        MulDivBusy_40
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles_40,
    output logic [15:0] FlushCount_40
`endif
);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;

    assign load_use = MemRead_EX_40 && (Rt_EX_40 != 5'd0) &&
                      ((Rt_EX_40 == Rs_ID_40) || (Rt_EX_40 == Rt_ID_40));

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        PCWrite_40       = 1'b1;
        IF_ID_Write_40   = 1'b1;
        IF_ID_Flush_40   = 1'b0;
        ID_EX_Bubble_40  = 1'b0;
        EX_MEM_Write_40  = 1'b1;
        EX_MEM_Bubble_40 = 1'b0;
        MulDivBusy_40    = 1'b0;
        if (!Reset_40) begin
            state_d          = RUN;
            cnt_d            = '0;
            PCWrite_40       = 1'b0;
            IF_ID_Write_40   = 1'b0;
            IF_ID_Flush_40   = 1'b1;
            ID_EX_Bubble_40  = 1'b1;
            EX_MEM_Write_40  = 1'b0;
            EX_MEM_Bubble_40 = 1'b1;
        end else if (state_q == MD_BUSY) begin
            // Counter at zero: the result lands in EX/MEM on this edge, so run normally.
            if (cnt_q == '0) begin
                state_d = RUN;
            end else begin
                cnt_d            = cnt_q - 1'b1;
                PCWrite_40       = 1'b0;
                IF_ID_Write_40   = 1'b0;
                EX_MEM_Bubble_40 = 1'b1;
                MulDivBusy_40    = 1'b1;
            end
        end else if (BranchTaken_EX_40) begin
            IF_ID_Flush_40  = 1'b1;
            ID_EX_Bubble_40 = 1'b1;
        end else if (MulDivStart_EX_40) begin
            // Hold the op in EX: no ID/EX bubble, EX/MEM fed a bubble instead.
            state_d          = MD_BUSY;
            cnt_d            = CNT_W'(MULDIV_LAT - 2);
            PCWrite_40       = 1'b0;
            IF_ID_Write_40   = 1'b0;
            EX_MEM_Bubble_40 = 1'b1;
        end else if (load_use) begin
            PCWrite_40      = 1'b0;
            IF_ID_Write_40  = 1'b0;
            ID_EX_Bubble_40 = 1'b1;
        end
    end

    always_ff @(posedge Clk_40 or negedge Reset_40) begin
        if (!Reset_40) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!PCWrite_40 && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
        if (IF_ID_Flush_40)
            flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge Clk_40 or negedge Reset_40) begin
        if (!Reset_40) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign StallCycles_40 = stall_q;
    assign FlushCount_40  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, random RUN vectors, mul/div and async-reset sequences.
// Also checks the counters when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
    localparam int LAT = 8;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, EX_MEM_Bubble, MulDivBusy}
    localparam logic [6:0] O_RST  = 7'b0011010;
    localparam logic [6:0] O_RUN  = 7'b1100100;
    localparam logic [6:0] O_LU   = 7'b0001100;
    localparam logic [6:0] O_BR   = 7'b1111100;
    localparam logic [6:0] O_MDS  = 7'b0000110;
    localparam logic [6:0] O_BUSY = 7'b0000111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_id, rt_id, rt_ex;
    logic       mem_read, br_taken, md_start;
    logic       pc_w, ifid_w, ifid_f, idex_b, exmem_w, exmem_b, md_busy;
    logic [6:0] outs;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(8)) dut (
        .Clk_40(clk), .Reset_40(rst_n),
        .Rs_ID_40(rs_id), .Rt_ID_40(rt_id),
        .MemRead_EX_40(mem_read), .Rt_EX_40(rt_ex),
        .BranchTaken_EX_40(br_taken), .MulDivStart_EX_40(md_start),
        .PCWrite_40(pc_w), .IF_ID_Write_40(ifid_w), .IF_ID_Flush_40(ifid_f),
        .ID_EX_Bubble_40(idex_b), .EX_MEM_Write_40(exmem_w),
        .EX_MEM_Bubble_40(exmem_b), .MulDivBusy_40(md_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles_40(stall_cycles), .FlushCount_40(flush_count)
`endif
    );

    assign outs = {pc_w, ifid_w, ifid_f, idex_b, exmem_w, exmem_b, md_busy};

    typedef struct {
        logic [4:0] rs, rt, rt_ex;
        logic       mr, br, md;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check_out(input string name);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty, got %b", name, outs);
            return;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (outs !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, outs, e);
        end
    endtask

    task automatic set_inputs(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rtx, input logic mr, input logic br, input logic md);
        rst_n = rst; rs_id = rs; rt_id = rt; rt_ex = rtx;
        mem_read = mr; br_taken = br; md_start = md;
    endtask

    // One clock: drive after the rising edge, compare on the falling edge.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rtx, input logic mr, input logic br, input logic md,
                        input logic [6:0] exp, input string name);
        @(posedge clk);
        #1;
        set_inputs(rst, rs, rt, rtx, mr, br, md);
        exp_q.push_back(exp);
        @(negedge clk);
        check_out(name);
    endtask

    task automatic idle(input logic [6:0] exp, input string name);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, name);
    endtask

    function automatic logic [6:0] run_model(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rtx, input logic mr, input logic br);
        if (br) return O_BR;
        if (mr && rtx != 5'd0 && (rtx == rs || rtx == rt)) return O_LU;
        return O_RUN;
    endfunction

    // Start pulse, busy cycles with noisy (ignored) inputs, then back to RUN.
    task automatic muldiv_seq(input string name);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_MDS, {name, "_start"});
        for (int i = 0; i < LAT - 2; i++) begin
            logic [4:0] r;
            r = 5'($urandom_range(1, 31));
            step(1'b1, r, r, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), O_BUSY, {name, "_busy"});
        end
        idle(O_RUN, {name, "_done"});
        idle(O_RUN, {name, "_after"});
    endtask

    initial begin
        vecs[0] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, O_RUN};
        vecs[1] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, O_LU};
        vecs[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, O_RUN};
        vecs[3] = '{5'd3,  5'd12, 5'd12, 1'b1, 1'b0, 1'b0, O_LU};
        vecs[4] = '{5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, O_RUN};
        vecs[5] = '{5'd6,  5'd8,  5'd7,  1'b1, 1'b0, 1'b0, O_RUN};
        vecs[6] = '{5'd1,  5'd9,  5'd9,  1'b1, 1'b1, 1'b0, O_BR};
        vecs[7] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, O_BR};
        vecs[8] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, O_BR};
        vecs[9] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, O_RUN};

        // Reset held low three cycles with all inputs zero.
        set_inputs(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, "reset_hold");
        idle(O_RUN, "reset_release");

        for (int i = 0; i < 10; i++)
            step(1'b1, vecs[i].rs, vecs[i].rt, vecs[i].rt_ex, vecs[i].mr, vecs[i].br,
                 vecs[i].md, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            logic [4:0] rs, rt, rtx;
            logic mr, br;
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            rtx = 5'($urandom_range(0, 3));
            mr  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 4) == 0);
            step(1'b1, rs, rt, rtx, mr, br, 1'b0, run_model(rs, rt, rtx, mr, br), "rand_run");
        end

        muldiv_seq("md1");

        // Async reset in the busy cycle where the counter reads 3.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_MDS, "md2_start");
        for (int i = 0; i < 3; i++)
            idle(O_BUSY, "md2_busy");
        @(posedge clk);
        #1;
        set_inputs(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(O_BUSY);
        #2;
        check_out("md2_busy_cnt3");
        rst_n = 1'b0;
        exp_q.push_back(O_RST);
        #1;
        check_out("md2_async_reset");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, "md2_reset_hold");
        idle(O_RUN, "md2_release");
        muldiv_seq("md3");

`ifdef HAZARD_PERF_CNT_EN
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, "perf_reset");
        idle(O_RUN, "perf_release");
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, O_LU, "perf_lu");
        idle(O_RUN, "perf_idle");
        muldiv_seq("perf_md");
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_BR, "perf_br1");
        idle(O_RUN, "perf_idle");
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_BR, "perf_br2");
        idle(O_RUN, "perf_idle");
        n_cmp++;
        if (stall_cycles !== 32'd8) begin
            n_err++;
            $display("FAIL stall_cycles: got %0d expected 8", stall_cycles);
        end
        n_cmp++;
        if (flush_count !== 16'd2) begin
            n_err++;
            $display("FAIL flush_count: got %0d expected 2", flush_count);
        end
`endif

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
